hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core (F/D/E/M/W). Drives stall/flush
//  of the inter-stage registers (FlushE -> CLR of the D/E register), operand forwarding

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl_fwd_sel.sv | 32 +++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: FSM state, forwarding select codes and register
// constants shared by the hazard controller and its sub-modules.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    MEMERR  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard unit bundle. slave = hazard unit
// (takes reg ids/stage flags, drives fwd/stall/flush/status); master = pipeline.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic [3:0]       RA1D, RA2D, RA1E, RA2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW;
  logic             MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic             BranchTakenE;
  logic             MemReqM, MemAckM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E,
    input  WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW,
    input  BranchTakenE, MemReqM, MemAckM,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output MemErr, StallCnt
  );

  modport master (
    output RA1D, RA2D, RA1E, RA2E,
    output WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW,
    output BranchTakenE, MemReqM, MemAckM,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  MemErr, StallCnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: operand forwarding select for one Execute source register.
// Ports: i_ra, i_wa3m/w, i_regwrite_m/w in; o_fwd (FWD_RD/W/M) out.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [3:0] i_ra,
  input  logic [3:0] i_wa3m,
  input  logic [3:0] i_wa3w,
  input  logic       i_regwrite_m,
  input  logic       i_regwrite_w,
  output logic [1:0] o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  // W hit is masked by M hit so the decode below is one-hot.
  assign w_hit_m = i_regwrite_m & (i_ra == i_wa3m)
                 & (i_ra != REG_PC);
  assign w_hit_w = i_regwrite_w & (i_ra == i_wa3w)
                 & (i_ra != REG_PC) & ~w_hit_m;

  always_comb begin
    o_fwd = FWD_RD;
    unique case (1'b1)
      w_hit_m: o_fwd = FWD_M;
      w_hit_w: o_fwd = FWD_W;
      default: o_fwd = FWD_RD;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control, memory-wait FSM with timeout.
// Ports: CLK, RST_N (async low), hz (hazard_ctrl_if.slave).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  hazard_ctrl_if.slave hz
);

  localparam int TW = $clog2(MEM_TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [TW-1:0]    r_wait, w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_ldr, w_pc_pend, w_mem_stall, w_hold;
  logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic       w_flush_d, w_flush_e, w_flush_w;
  logic [1:0] w_fa, w_fb;

  fwd_sel u_fwd_a (
    .i_ra         (hz.RA1E),
    .i_wa3m       (hz.WA3M),
    .i_wa3w       (hz.WA3W),
    .i_regwrite_m (hz.RegWriteM),
    .i_regwrite_w (hz.RegWriteW),
    .o_fwd        (w_fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_ra         (hz.RA2E),
    .i_wa3m       (hz.WA3M),
    .i_wa3w       (hz.WA3W),
    .i_regwrite_m (hz.RegWriteM),
    .i_regwrite_w (hz.RegWriteW),
    .o_fwd        (w_fwd_b)
  );

  assign w_ldr = hz.MemtoRegE
               & ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));
  assign w_pc_pend   = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;
  assign w_mem_stall = hz.MemReqM & ~hz.MemAckM;

  // Freeze whole pipe while memory is outstanding or after timeout.
  assign w_hold = RST_N & ((r_state == MEMERR) | w_mem_stall);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= RUN;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    unique case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = MEMWAIT;
          w_wait_nxt  = '0;
        end
      end
      MEMWAIT: begin
        // Ack wins over a timeout landing in the same cycle.
        if (hz.MemAckM) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = MEMERR;
        end else begin
          w_wait_nxt = r_wait + TW'(1);
        end
      end
      MEMERR:  w_state_nxt = MEMERR;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_stall_f = w_ldr | w_pc_pend;
    w_stall_d = w_ldr;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = w_pc_pend | hz.PCSrcW | hz.BranchTakenE;
    w_flush_e = w_ldr | hz.BranchTakenE;
    w_flush_w = 1'b0;
    w_fa      = w_fwd_a;
    w_fb      = w_fwd_b;
    unique case (1'b1)
      !RST_N: begin
        // Drain to bubbles while reset is held.
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
        w_flush_w = 1'b1;
        w_fa      = FWD_RD;
        w_fb      = FWD_RD;
      end
      w_hold: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign hz.ForwardAE = w_fa;
  assign hz.ForwardBE = w_fb;
  assign hz.StallF    = w_stall_f;
  assign hz.StallD    = w_stall_d;
  assign hz.StallE    = w_stall_e;
  assign hz.StallM    = w_stall_m;
  assign hz.FlushD    = w_flush_d;
  assign hz.FlushE    = w_flush_e;
  assign hz.FlushW    = w_flush_w;
  assign hz.MemErr    = (r_state == MEMERR);
  assign hz.StallCnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl (CNT_W=16 main
// instance plus a CNT_W=4 twin sharing the same inputs).
module tb_hazard_ctrl;

  logic CLK;
  logic RST_N;
  int   pass_cnt;
  int   total_cnt;

  hazard_ctrl_if #(.CNT_W(16)) hz ();
  hazard_ctrl_if #(.CNT_W(4))  hz4 ();

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .hz    (hz.slave)
  );

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .hz    (hz4.slave)
  );

  assign hz4.RA1D         = hz.RA1D;
  assign hz4.RA2D         = hz.RA2D;
  assign hz4.RA1E         = hz.RA1E;
  assign hz4.RA2E         = hz.RA2E;
  assign hz4.WA3E         = hz.WA3E;
  assign hz4.WA3M         = hz.WA3M;
  assign hz4.WA3W         = hz.WA3W;
  assign hz4.RegWriteM    = hz.RegWriteM;
  assign hz4.RegWriteW    = hz.RegWriteW;
  assign hz4.MemtoRegE    = hz.MemtoRegE;
  assign hz4.PCSrcD       = hz.PCSrcD;
  assign hz4.PCSrcE       = hz.PCSrcE;
  assign hz4.PCSrcM       = hz.PCSrcM;
  assign hz4.PCSrcW       = hz.PCSrcW;
  assign hz4.BranchTakenE = hz.BranchTakenE;
  assign hz4.MemReqM      = hz.MemReqM;
  assign hz4.MemAckM      = hz.MemAckM;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  function automatic logic [6:0] ctl();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.FlushW};
  endfunction

  task automatic clr();
    hz.RA1D = 4'd0; hz.RA2D = 4'd0;
    hz.RA1E = 4'd0; hz.RA2E = 4'd0;
    hz.WA3E = 4'd9; hz.WA3M = 4'd0; hz.WA3W = 4'd0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemtoRegE = 1'b0;
    hz.PCSrcD = 1'b0; hz.PCSrcE = 1'b0;
    hz.PCSrcM = 1'b0; hz.PCSrcW = 1'b0;
    hz.BranchTakenE = 1'b0;
    hz.MemReqM = 1'b0; hz.MemAckM = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    clr();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    clr();
    @(negedge CLK);
    hz.PCSrcD = 1'b1; hz.MemReqM = 1'b1;
    hz.RegWriteM = 1'b1; hz.WA3M = 4'd3; hz.RA1E = 4'd3;
    #1;
    total_cnt++;
    if (ctl() !== 7'b0000_111)
      $display("FAIL reset_ctl got %b want %b", ctl(), 7'b0000_111);
    else pass_cnt++;
    total_cnt++;
    if (hz.ForwardAE !== 2'b00)
      $display("FAIL reset_fwd got %b want 00", hz.ForwardAE);
    else pass_cnt++;
    total_cnt++;
    if (hz.MemErr !== 1'b0 || hz.StallCnt !== 16'd0)
      $display("FAIL reset_stat got %b/%0d want 0/0",
               hz.MemErr, hz.StallCnt);
    else pass_cnt++;
    @(negedge CLK);
    clr();
    RST_N = 1'b1;
  endtask

  task automatic test_forward();
    @(negedge CLK);
    clr();
    hz.RegWriteM = 1'b1; hz.WA3M = 4'd3;
    hz.RegWriteW = 1'b1; hz.WA3W = 4'd3;
    hz.RA1E = 4'd3; hz.RA2E = 4'd3;
    #1;
    total_cnt++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b10_10)
      $display("FAIL fwd_m_prio got %b%b want 1010",
               hz.ForwardAE, hz.ForwardBE);
    else pass_cnt++;
    @(negedge CLK);
    hz.RA1E = 4'd15; hz.WA3M = 4'd15; hz.WA3W = 4'd15;
    #1;
    total_cnt++;
    if (hz.ForwardAE !== 2'b00)
      $display("FAIL fwd_r15 got %b want 00", hz.ForwardAE);
    else pass_cnt++;
    @(negedge CLK);
    clr();
    hz.RegWriteM = 1'b0; hz.WA3M = 4'd4;
    hz.RegWriteW = 1'b1; hz.WA3W = 4'd4;
    hz.RA1E = 4'd5; hz.RA2E = 4'd4;
    #1;
    total_cnt++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b00_01)
      $display("FAIL fwd_w_only got %b%b want 0001",
               hz.ForwardAE, hz.ForwardBE);
    else pass_cnt++;
    @(negedge CLK);
    hz.RegWriteM = 1'b1; hz.WA3M = 4'd7;
    hz.RegWriteW = 1'b1; hz.WA3W = 4'd2;
    hz.RA1E = 4'd7; hz.RA2E = 4'd2;
    #1;
    total_cnt++;
    if ({hz.ForwardAE, hz.ForwardBE} !== 4'b10_01)
      $display("FAIL fwd_mixed got %b%b want 1001",
               hz.ForwardAE, hz.ForwardBE);
    else pass_cnt++;
  endtask

  task automatic test_ldr_stall();
    @(negedge CLK);
    clr();
    hz.MemtoRegE = 1'b1; hz.WA3E = 4'd5; hz.RA2D = 4'd5;
    #1;
    total_cnt++;
    if (ctl() !== 7'b1100_010)
      $display("FAIL ldr_stall got %b want %b", ctl(), 7'b1100_010);
    else pass_cnt++;
    @(negedge CLK);
    hz.MemtoRegE = 1'b0;
    #1;
    total_cnt++;
    if (ctl() !== 7'b0000_000)
      $display("FAIL ldr_release got %b want %b", ctl(), 7'b0);
    else pass_cnt++;
    @(negedge CLK);
    hz.MemtoRegE = 1'b1; hz.WA3E = 4'd6; hz.RA1D = 4'd6;
    hz.RA2D = 4'd1; hz.BranchTakenE = 1'b1;
    #1;
    total_cnt++;
    if (ctl() !== 7'b1100_110)
      $display("FAIL ldr_branch got %b want %b", ctl(), 7'b1100_110);
    else pass_cnt++;
  endtask

  task automatic test_pc_pend();
    logic [6:0] exp [5];
    exp[0] = 7'b1000_100;
    exp[1] = 7'b1000_100;
    exp[2] = 7'b1000_100;
    exp[3] = 7'b0000_100;
    exp[4] = 7'b0000_000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      clr();
      hz.PCSrcD = (i == 0);
      hz.PCSrcE = (i == 1);
      hz.PCSrcM = (i == 2);
      hz.PCSrcW = (i == 3);
      #1;
      total_cnt++;
      if (ctl() !== exp[i])
        $display("FAIL pc_pend_c%0d got %b want %b",
                 i + 1, ctl(), exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      hz.MemReqM = 1'b1; hz.MemAckM = 1'b0;
      hz.BranchTakenE = 1'b1; hz.PCSrcD = 1'b1;
      #1;
      total_cnt++;
      if (ctl() !== 7'b1111_001)
        $display("FAIL mem_stall_c%0d got %b want %b",
                 i, ctl(), 7'b1111_001);
      else pass_cnt++;
    end
    @(negedge CLK);
    clr();
    hz.MemReqM = 1'b1; hz.MemAckM = 1'b1;
    #1;
    total_cnt++;
    if (ctl() !== 7'b0000_000 || hz.StallCnt !== 16'd3)
      $display("FAIL mem_ack got %b/%0d want %b/3",
               ctl(), hz.StallCnt, 7'b0);
    else pass_cnt++;
    @(negedge CLK);
    clr();
    @(negedge CLK);
    hz.MemReqM = 1'b1; hz.MemAckM = 1'b1;
    #1;
    total_cnt++;
    if (ctl() !== 7'b0000_000 || hz.StallCnt !== 16'd3)
      $display("FAIL mem_fast_ack got %b/%0d want %b/3",
               ctl(), hz.StallCnt, 7'b0);
    else pass_cnt++;
  endtask

  task automatic test_mem_timeout();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      hz.MemReqM = 1'b1; hz.MemAckM = 1'b0;
      #1;
      if (i == 17) begin
        total_cnt++;
        if (hz.MemErr !== 1'b0)
          $display("FAIL tmo_early got %b want 0", hz.MemErr);
        else pass_cnt++;
      end
    end
    @(negedge CLK);
    clr();
    hz.MemAckM = 1'b1; hz.PCSrcW = 1'b1;
    #1;
    total_cnt++;
    if (hz.MemErr !== 1'b1 || ctl() !== 7'b1111_001)
      $display("FAIL tmo_err got %b/%b want 1/%b",
               hz.MemErr, ctl(), 7'b1111_001);
    else pass_cnt++;
    total_cnt++;
    if (hz.StallCnt !== 16'd17 || hz4.StallCnt !== 4'd15)
      $display("FAIL tmo_cnt got %0d/%0d want 17/15",
               hz.StallCnt, hz4.StallCnt);
    else pass_cnt++;
    @(negedge CLK);
    clr();
    #1;
    total_cnt++;
    if (hz.MemErr !== 1'b1 || hz.StallF !== 1'b1)
      $display("FAIL tmo_sticky got %b/%b want 1/1",
               hz.MemErr, hz.StallF);
    else pass_cnt++;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    total_cnt++;
    if (hz.MemErr !== 1'b0 || hz.StallCnt !== 16'd0
        || ctl() !== 7'b0000_111)
      $display("FAIL tmo_rst got %b/%0d/%b want 0/0/%b",
               hz.MemErr, hz.StallCnt, ctl(), 7'b0000_111);
    else pass_cnt++;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    #1;
    total_cnt++;
    if (hz.MemErr !== 1'b0 || ctl() !== 7'b0000_000)
      $display("FAIL tmo_after_rst got %b/%b want 0/%b",
               hz.MemErr, ctl(), 7'b0);
    else pass_cnt++;
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      @(negedge CLK);
      hz.MemReqM = 1'b1;
      hz.MemAckM = (i == 17);
    end
    @(negedge CLK);
    clr();
    #1;
    total_cnt++;
    if (hz.MemErr !== 1'b0 || hz.StallF !== 1'b0
        || hz.StallCnt !== 16'd16)
      $display("FAIL ack_vs_tmo got %b/%b/%0d want 0/0/16",
               hz.MemErr, hz.StallF, hz.StallCnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 21; i++) begin
      @(negedge CLK);
      hz.PCSrcD = 1'b1;
      #1;
      if (i == 16) begin
        total_cnt++;
        if (hz.StallCnt !== 16'd15 || hz4.StallCnt !== 4'd15)
          $display("FAIL sat_reach got %0d/%0d want 15/15",
                   hz.StallCnt, hz4.StallCnt);
        else pass_cnt++;
      end
      if (i == 21) begin
        total_cnt++;
        if (hz.StallCnt !== 16'd20 || hz4.StallCnt !== 4'd15)
          $display("FAIL sat_hold got %0d/%0d want 20/15",
                   hz.StallCnt, hz4.StallCnt);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_forward();
    test_ldr_stall();
    test_pc_pend();
    test_mem_wait();
    test_mem_timeout();
    test_ack_at_timeout();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
